// File: rtl/fetch_channel_resp.sv
// Responder end of the instruction-fetch index channel: one DDR burst per
// accepted index, beats assembled into a full line and handed to the ibuffer.
module fetch_channel_resp #(
  parameter int BEATS  = 8,
  parameter int DATA_W = 64,
  parameter int IDX_W  = 19
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pc_index_valid,
  input  logic [IDX_W-1:0]        pc_index,
  output logic                    pc_index_ready,
  output logic                    pc_operation_done,
  input  logic                    flush,
  output logic                    ddr_rd_req_valid,
  input  logic                    ddr_rd_req_ready,
  output logic [IDX_W-1:0]        ddr_rd_addr,
  input  logic                    ddr_rd_data_valid,
  input  logic [DATA_W-1:0]       ddr_rd_data,
  output logic                    line_valid,
  output logic [BEATS*DATA_W-1:0] line_data,
  output logic [IDX_W-1:0]        line_index
);

  localparam int CNT_W = $clog2(BEATS);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] beat_cnt;
  logic             drop;

  assign pc_index_ready = (state == IDLE);

  always_comb begin
    state_next        = state;
    ddr_rd_req_valid  = 1'b0;
    line_valid        = 1'b0;
    pc_operation_done = 1'b0;
    case (state)
      IDLE: if (pc_index_valid) state_next = REQ;
      REQ: begin
        ddr_rd_req_valid = 1'b1;
        if (ddr_rd_req_ready) state_next = RECV;
      end
      RECV: if (ddr_rd_data_valid && beat_cnt == CNT_W'(BEATS - 1)) state_next = DONE;
      DONE: begin
        // A flush arriving in the delivery cycle itself still kills the pulses.
        line_valid        = !(drop || flush);
        pc_operation_done = !(drop || flush);
        state_next        = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The burst is always drained even when dropped, so DDR never sees an
  // abandoned request; drop only gates the final delivery pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      drop        <= 1'b0;
      ddr_rd_addr <= '0;
      line_index  <= '0;
      line_data   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pc_index_valid) begin
            ddr_rd_addr <= pc_index;
            line_index  <= pc_index;
            drop        <= 1'b0;
          end
        end
        REQ: begin
          if (flush) drop <= 1'b1;
          if (ddr_rd_req_ready) beat_cnt <= '0;
        end
        RECV: begin
          if (flush) drop <= 1'b1;
          if (ddr_rd_data_valid) begin
            line_data[int'(beat_cnt)*DATA_W +: DATA_W] <= ddr_rd_data;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        DONE: begin
          if (flush) drop <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_channel_resp.sv
// Scoreboard bench for fetch_channel_resp: expected lines are queued at the
// handshake and popped when the DUT pulses line_valid.
module tb_fetch_channel_resp;

  localparam int BEATS  = 8;
  localparam int DATA_W = 64;
  localparam int IDX_W  = 19;
  localparam int LINE_W = BEATS * DATA_W;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              pc_index_valid;
  logic [IDX_W-1:0]  pc_index;
  logic              pc_index_ready;
  logic              pc_operation_done;
  logic              flush;
  logic              ddr_rd_req_valid;
  logic              ddr_rd_req_ready;
  logic [IDX_W-1:0]  ddr_rd_addr;
  logic              ddr_rd_data_valid;
  logic [DATA_W-1:0] ddr_rd_data;
  logic              line_valid;
  logic [LINE_W-1:0] line_data;
  logic [IDX_W-1:0]  line_index;

  typedef struct {
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] data;
  } line_t;

  line_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  fetch_channel_resp #(.BEATS(BEATS), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .pc_index_valid    (pc_index_valid),
    .pc_index          (pc_index),
    .pc_index_ready    (pc_index_ready),
    .pc_operation_done (pc_operation_done),
    .flush             (flush),
    .ddr_rd_req_valid  (ddr_rd_req_valid),
    .ddr_rd_req_ready  (ddr_rd_req_ready),
    .ddr_rd_addr       (ddr_rd_addr),
    .ddr_rd_data_valid (ddr_rd_data_valid),
    .ddr_rd_data       (ddr_rd_data),
    .line_valid        (line_valid),
    .line_data         (line_data),
    .line_index        (line_index)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_expected(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] base);
    line_t item;
    item.idx = idx;
    for (int k = 0; k < BEATS; k++) item.data[k*DATA_W +: DATA_W] = base + DATA_W'(k);
    exp_q.push_back(item);
  endtask

  // Handshake: leaves the DUT in REQ, #1 after the handshake edge.
  task automatic start_req(input logic [IDX_W-1:0] idx);
    pc_index_valid = 1'b1;
    pc_index       = idx;
    tick();
    pc_index_valid = 1'b0;
  endtask

  task automatic accept_req();
    ddr_rd_req_ready = 1'b1;
    tick();
    ddr_rd_req_ready = 1'b0;
  endtask

  // Leaves the DUT in DONE, #1 after the edge that captured the last beat.
  task automatic send_beats(input logic [DATA_W-1:0] base, input int gap, input int flush_at);
    for (int k = 0; k < BEATS; k++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = base + DATA_W'(k);
      tick();
      ddr_rd_data_valid = 1'b0;
      ddr_rd_data       = '0;
      if (k == flush_at) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      if (gap > 0 && k != BEATS - 1) repeat (gap) tick();
    end
  endtask

  task automatic test_reset();
    reset_n           = 1'b0;
    pc_index_valid    = 1'b0;
    pc_index          = '0;
    flush             = 1'b0;
    ddr_rd_req_ready  = 1'b0;
    ddr_rd_data_valid = 1'b0;
    ddr_rd_data       = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_total++;
    if (pc_index_ready !== 1'b1) $display("FAIL reset_ready: got %b need 1", pc_index_ready);
    else n_pass++;
    n_total++;
    if ({pc_operation_done, ddr_rd_req_valid, line_valid} !== 3'b000)
      $display("FAIL reset_pulses: got %b need 000", {pc_operation_done, ddr_rd_req_valid, line_valid});
    else n_pass++;
    n_total++;
    if (line_data !== '0 || line_index !== '0 || ddr_rd_addr !== '0)
      $display("FAIL reset_regs: got idx %h addr %h need 0", line_index, ddr_rd_addr);
    else n_pass++;
    @(posedge clock);
    #1 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_fetch();
    line_t item;
    push_expected(19'h00010, 64'h1111_0000_0000_0000);
    start_req(19'h00010);
    @(negedge clock);
    n_total++;
    if (ddr_rd_req_valid !== 1'b1 || ddr_rd_addr !== 19'h00010)
      $display("FAIL basic_req: got valid %b addr %h need 1 00010", ddr_rd_req_valid, ddr_rd_addr);
    else n_pass++;
    #1 accept_req();
    send_beats(64'h1111_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_operation_done !== 1'b1)
      $display("FAIL basic_pulse_cycle10: got lv %b done %b need 1 1", line_valid, pc_operation_done);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL basic_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_index !== item.idx) $display("FAIL basic_index: got %h need %h", line_index, item.idx);
        else n_pass++;
        n_total++;
        if (line_data !== item.data) $display("FAIL basic_data: got %h need %h", line_data, item.data);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_backpressure_gaps();
    line_t item;
    push_expected(19'h00020, 64'h2222_0000_0000_0000);
    start_req(19'h00020);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        ddr_rd_data_valid = 1'b1;
        ddr_rd_data       = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      @(negedge clock);
      n_total++;
      if (ddr_rd_req_valid !== 1'b1 || ddr_rd_addr !== 19'h00020 || pc_index_ready !== 1'b0)
        $display("FAIL stall_%0d: got valid %b addr %h ready %b need 1 00020 0",
                 i, ddr_rd_req_valid, ddr_rd_addr, pc_index_ready);
      else n_pass++;
      tick();
      ddr_rd_data_valid = 1'b0;
      ddr_rd_data       = '0;
    end
    accept_req();
    send_beats(64'h2222_0000_0000_0000, 1, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_operation_done !== 1'b1 || pc_index_ready !== 1'b0)
      $display("FAIL gap_done: got lv %b done %b ready %b need 1 1 0",
               line_valid, pc_operation_done, pc_index_ready);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL gap_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_data !== item.data || line_index !== item.idx)
          $display("FAIL gap_line: got %h idx %h need %h idx %h", line_data, line_index, item.data, item.idx);
        else n_pass++;
      end
    end
    tick();
    @(negedge clock);
    n_total++;
    if (pc_index_ready !== 1'b1) $display("FAIL gap_ready_after_done: got %b need 1", pc_index_ready);
    else n_pass++;
    #1;
  endtask

  task automatic test_flush_mid_burst();
    line_t item;
    start_req(19'h00030);
    accept_req();
    send_beats(64'h3333_0000_0000_0000, 0, 3);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b0 || pc_operation_done !== 1'b0)
      $display("FAIL flush_mid_pulses: got lv %b done %b need 0 0", line_valid, pc_operation_done);
    else n_pass++;
    tick();
    @(negedge clock);
    n_total++;
    if (pc_index_ready !== 1'b1) $display("FAIL flush_mid_ready: got %b need 1", pc_index_ready);
    else n_pass++;
    #1;
    push_expected(19'h00038, 64'h3838_0000_0000_0000);
    start_req(19'h00038);
    accept_req();
    send_beats(64'h3838_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_operation_done !== 1'b1)
      $display("FAIL flush_mid_next: got lv %b done %b need 1 1", line_valid, pc_operation_done);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL flush_mid_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_data !== item.data || line_index !== item.idx)
          $display("FAIL flush_mid_line: got %h idx %h need %h idx %h", line_data, line_index, item.data, item.idx);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_flush_req_done();
    line_t item;
    start_req(19'h00040);
    flush = 1'b1;
    @(negedge clock);
    n_total++;
    if (ddr_rd_req_valid !== 1'b1 || ddr_rd_addr !== 19'h00040)
      $display("FAIL flush_req_hold: got valid %b addr %h need 1 00040", ddr_rd_req_valid, ddr_rd_addr);
    else n_pass++;
    tick();
    flush = 1'b0;
    accept_req();
    send_beats(64'h4040_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b0 || pc_operation_done !== 1'b0)
      $display("FAIL flush_req_pulses: got lv %b done %b need 0 0", line_valid, pc_operation_done);
    else n_pass++;
    tick();
    start_req(19'h00048);
    accept_req();
    send_beats(64'h4848_0000_0000_0000, 0, -1);
    flush = 1'b1;
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b0 || pc_operation_done !== 1'b0)
      $display("FAIL flush_done_pulses: got lv %b done %b need 0 0", line_valid, pc_operation_done);
    else n_pass++;
    tick();
    flush = 1'b0;
    push_expected(19'h00050, 64'h5050_0000_0000_0000);
    start_req(19'h00050);
    accept_req();
    send_beats(64'h5050_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_operation_done !== 1'b1)
      $display("FAIL flush_after_pulse: got lv %b done %b need 1 1", line_valid, pc_operation_done);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL flush_after_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_data !== item.data || line_index !== item.idx)
          $display("FAIL flush_after_line: got %h idx %h need %h idx %h", line_data, line_index, item.data, item.idx);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    line_t item;
    pc_index_valid = 1'b1;
    pc_index       = 19'h00000;
    push_expected(19'h00000, 64'hB0B0_0000_0000_0000);
    tick();
    pc_index = 19'h00008;
    @(negedge clock);
    n_total++;
    if (pc_index_ready !== 1'b0) $display("FAIL b2b_ready_busy: got %b need 0", pc_index_ready);
    else n_pass++;
    #1 accept_req();
    send_beats(64'hB0B0_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_index_ready !== 1'b0)
      $display("FAIL b2b_first_done: got lv %b ready %b need 1 0", line_valid, pc_index_ready);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL b2b_first_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_data !== item.data || line_index !== item.idx)
          $display("FAIL b2b_first_line: got %h idx %h need %h idx %h", line_data, line_index, item.data, item.idx);
        else n_pass++;
      end
    end
    tick();
    @(negedge clock);
    n_total++;
    if (pc_index_ready !== 1'b1) $display("FAIL b2b_reaccept: got %b need 1", pc_index_ready);
    else n_pass++;
    push_expected(19'h00008, 64'hB8B8_0000_0000_0000);
    #1 tick();
    pc_index_valid = 1'b0;
    @(negedge clock);
    n_total++;
    if (ddr_rd_req_valid !== 1'b1 || ddr_rd_addr !== 19'h00008)
      $display("FAIL b2b_second_req: got valid %b addr %h need 1 00008", ddr_rd_req_valid, ddr_rd_addr);
    else n_pass++;
    #1 accept_req();
    send_beats(64'hB8B8_0000_0000_0000, 0, -1);
    @(negedge clock);
    n_total++;
    if (line_valid !== 1'b1 || pc_operation_done !== 1'b1)
      $display("FAIL b2b_second_pulse: got lv %b done %b need 1 1", line_valid, pc_operation_done);
    else n_pass++;
    if (line_valid === 1'b1) begin
      n_total++;
      if (exp_q.size() == 0) $display("FAIL b2b_second_unexpected_line: got line, need none");
      else begin
        item = exp_q.pop_front();
        n_pass++;
        n_total++;
        if (line_data !== item.data || line_index !== item.idx)
          $display("FAIL b2b_second_line: got %h idx %h need %h idx %h", line_data, line_index, item.data, item.idx);
        else n_pass++;
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_recv();
    start_req(19'h00060);
    accept_req();
    for (int k = 0; k < 3; k++) begin
      ddr_rd_data_valid = 1'b1;
      ddr_rd_data       = 64'h6060_0000_0000_0000 + DATA_W'(k);
      tick();
    end
    reset_n = 1'b0;
    #1;
    n_total++;
    if (pc_index_ready !== 1'b1 || ddr_rd_req_valid !== 1'b0 || line_valid !== 1'b0 || pc_operation_done !== 1'b0)
      $display("FAIL rst_mid_ctrl: got ready %b req %b lv %b done %b need 1 0 0 0",
               pc_index_ready, ddr_rd_req_valid, line_valid, pc_operation_done);
    else n_pass++;
    n_total++;
    if (line_data !== '0 || line_index !== '0 || ddr_rd_addr !== '0)
      $display("FAIL rst_mid_regs: got idx %h addr %h need 0 0", line_index, ddr_rd_addr);
    else n_pass++;
    tick();
    tick();
    reset_n = 1'b1;
    for (int k = 3; k < BEATS; k++) begin
      ddr_rd_data = 64'h6060_0000_0000_0000 + DATA_W'(k);
      @(negedge clock);
      n_total++;
      if (line_valid !== 1'b0 || pc_index_ready !== 1'b1 || line_data !== '0)
        $display("FAIL rst_stray_beat_%0d: got lv %b ready %b need 0 1 with zero line",
                 k, line_valid, pc_index_ready);
      else n_pass++;
      #1 tick();
    end
    ddr_rd_data_valid = 1'b0;
    ddr_rd_data       = '0;
    n_total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_leftover: got %0d lines pending need 0", exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_backpressure_gaps();
    test_flush_mid_burst();
    test_flush_req_done();
    test_back_to_back();
    test_reset_mid_recv();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_channel_resp.md
Name: fetch_channel_resp

Overview:
- Responder end of the instruction-fetch index channel.
- Accepts one fetch-line request per handshake on pc_index_valid/pc_index_ready and issues one DDR burst read for it.
- Assembles the returned beats into one 64-byte line and delivers it to the ibuffer.
- Pulses pc_operation_done to the PC controller when the line is delivered. A flush input discards any in-flight line.

Parameters:
- BEATS, 8, DDR data beats per fetch line (power of two, ≥2).
- DATA_W, 64, bits per DDR beat; the line is BEATS*DATA_W bits.
- IDX_W, 19, width of the fetch index (PC bits [21:3]).

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- pc_index_valid  input  1  fetch request valid
- pc_index  input  IDX_W  fetch line index
- pc_index_ready  output  1  request accepted when high together with pc_index_valid
- pc_operation_done  output  1  one-cycle pulse: line delivered
- flush  input  1  level; discard in-flight line (driven by clear_ibuffer)
- ddr_rd_req_valid  output  1  DDR burst read request
- ddr_rd_req_ready  input  1  DDR accepts request
- ddr_rd_addr  output  IDX_W  burst start index
- ddr_rd_data_valid  input  1  one beat valid this cycle
- ddr_rd_data  input  DATA_W  beat data, in-order, lowest address first
- line_valid  output  1  one-cycle pulse: line_data/line_index valid
- line_data  output  BEATS*DATA_W  assembled line
- line_index  output  IDX_W  index of delivered line

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low on reset_n.
- Reset values:
  - state=IDLE.
  - pc_index_ready=1 (combinational from IDLE).
  - All other outputs 0: pc_operation_done, ddr_rd_req_valid, line_valid, line_data, line_index, ddr_rd_addr.
  - Beat counter=0, drop flag=0.
- States:
  - IDLE → REQ, REQ → RECV, RECV → DONE, DONE → IDLE.
- IDLE:
  - pc_index_ready=1.
  - On pc_index_valid: capture pc_index into ddr_rd_addr and line_index, clear drop, go to REQ.
  - flush in IDLE has no effect.
- REQ:
  - ddr_rd_req_valid=1 from the cycle after the handshake.
  - Once asserted it holds stable until ddr_rd_req_ready, even if flush arrives.
  - On acceptance: clear the beat counter, go to RECV.
- RECV:
  - Each cycle with ddr_rd_data_valid writes beat k into line_data[k*DATA_W +: DATA_W], then increments k.
  - Gaps between beats are allowed.
  - When beat BEATS-1 is captured, go to DONE.
  - Beats arriving outside RECV are ignored.
- DONE (exactly one cycle):
  - If drop=0: line_valid=1 and pc_operation_done=1 for this cycle.
  - If drop=1: both stay 0 and the line is silently discarded.
  - Next state IDLE.
- Flush and drop:
  - flush sampled high in REQ, RECV or DONE sets drop.
  - flush in DONE suppresses that cycle's pulses; the drop decision uses drop OR flush.
  - The burst is always fully drained; the DDR request is never abandoned.
- pc_index_ready:
  - Low in REQ/RECV/DONE; only one outstanding request at a time.
  - Earliest re-acceptance is the cycle after DONE.
- Latency with no backpressure and back-to-back beats:
  - Handshake at cycle 0.
  - Request at cycle 1.
  - Beats at cycles 2..BEATS+1.
  - line_valid and pc_operation_done at cycle BEATS+2.
- Widths:
  - The beat counter is log2(BEATS) bits and wraps only via state reset.
  - ddr_rd_addr is held constant for the burst; DDR performs the internal address increment.
- Reset mid-operation returns immediately to the reset values. Beats still in flight after reset are ignored because state is IDLE.
- line_data holds its last value between pulses; it is not cleared except by reset.

Test Plan:
- Basic fetch:
  - Stimulus: pc_index=0x00010; DDR ready immediately; beats 0x1111_0000_0000_0000+k, k=0..7, back-to-back.
  - Response: ddr_rd_addr=0x00010; line_valid and pc_operation_done pulse at cycle 10; line_data[63:0]=0x1111000000000000 and [511:448]=0x1111000000000007; line_index=0x00010.
- DDR backpressure and gapped beats:
  - Stimulus: ddr_rd_req_ready low 5 cycles; one idle cycle between each beat.
  - Response: req_valid and addr stable throughout the stall; line assembled identically; pc_index_ready=0 until the cycle after DONE.
- Flush mid-burst:
  - Stimulus: flush pulsed for 1 cycle after beat 3.
  - Response: remaining 4 beats consumed; no line_valid and no pc_operation_done; the next request is accepted normally.
- Flush in REQ and in the DONE cycle:
  - Response: in both cases no pulses and no stray beat capture; the following request delivers correct data.
- Back-to-back requests:
  - Stimulus: pc_index_valid held high with indices 0x00000 then 0x00008.
  - Response: the second handshake occurs the cycle after the first DONE; two lines are delivered in order with the correct line_index.
- Reset mid-RECV:
  - Stimulus: reset_n low after beat 2, then beats continue to arrive.
  - Response: all outputs return to reset values, pc_index_ready=1, and the arriving beats are ignored.
